// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared FIFO pointer helpers (depth/width derivation, Gray conversion)
// Gray helpers work on zero-extended values up to PTR_MAX_W bits; callers size-cast the result.
package fifo_pkg;

  localparam int unsigned PTR_MAX_W = 32;

  function automatic int unsigned fifo_depth(input int unsigned addr_w);
    return 32'd1 << addr_w;
  endfunction

  function automatic int unsigned ptr_width(input int unsigned addr_w);
    return addr_w + 32'd1;
  endfunction

  function automatic logic [PTR_MAX_W-1:0] bin2gray(input logic [PTR_MAX_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [PTR_MAX_W-1:0] gray2bin(input logic [PTR_MAX_W-1:0] g);
    logic [PTR_MAX_W-1:0] b;
    b[PTR_MAX_W-1] = g[PTR_MAX_W-1];
    for (int i = PTR_MAX_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/gray_sync.sv
// rtl/gray_sync.sv - WIDTH x STAGES flop chain for bringing a Gray pointer across clock domains
module gray_sync #(
  parameter int WIDTH  = 7,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] stage_q [STAGES];

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      for (int i = 0; i < STAGES; i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      stage_q[0] <= d_i;
      for (int i = 1; i < STAGES; i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign q_o = stage_q[STAGES-1];

endmodule

// File: rtl/fifo_wr_ctrl.sv
// rtl/fifo_wr_ctrl.sv - async FIFO write-side controller; FIFO_WR_ALMOST_FULL_EN builds w_fill/almost_full
module fifo_wr_ctrl
  import fifo_pkg::*;
#(
  parameter int ADDR_W      = 6,
  parameter int AF_LEVEL    = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic              w_clk,
  input  logic              n_rst,
  input  logic              w_en_i,
  input  logic              ovf_clr_i,
  input  logic [ADDR_W:0]   rptr_gray_i,
  output logic [ADDR_W-1:0] w_addr_o,
  output logic [ADDR_W:0]   wptr_gray_o,
  output logic              full_o,
  output logic              almost_full_o,
  output logic [ADDR_W:0]   w_fill_o,
  output logic              overflow_o
);

  localparam int PW    = int'(ptr_width(ADDR_W));
  localparam int DEPTH = int'(fifo_depth(ADDR_W));

  logic [PW-1:0] wbin_q, wbin_d;
  logic [PW-1:0] wgray_q, wgray_d;
  logic [PW-1:0] fill_q, fill_d;
  logic          full_q, full_d;
  logic          af_q, af_d;
  logic          ovf_q, ovf_d;
  logic [PW-1:0] rgray_s;
  logic          accept;

  // The flag registers form the last synchroniser stage, so the chain itself is one shorter.
  gray_sync #(
    .WIDTH  (PW),
    .STAGES (SYNC_STAGES - 1)
  ) u_rptr_sync (
    .clk   (w_clk),
    .n_rst (n_rst),
    .d_i   (rptr_gray_i),
    .q_o   (rgray_s)
  );

  always_comb begin
    accept  = w_en_i & ~full_q;
    wbin_d  = wbin_q + {{(PW-1){1'b0}}, accept};
    wgray_d = PW'(bin2gray(PTR_MAX_W'(wbin_d)));
    full_d  = (wgray_d == {~rgray_s[PW-1:PW-2], rgray_s[PW-3:0]});
    ovf_d   = (w_en_i & full_q) | (ovf_q & ~ovf_clr_i);
  end

`ifdef FIFO_WR_ALMOST_FULL_EN
  logic [PW-1:0] rbin_s;

  always_comb begin
    rbin_s = PW'(gray2bin(PTR_MAX_W'(rgray_s)));
    fill_d = wbin_d - rbin_s;
    af_d   = (fill_d >= PW'(DEPTH - AF_LEVEL));
  end
`else
  always_comb begin
    fill_d = '0;
    af_d   = 1'b0;
  end
`endif

  always_ff @(posedge w_clk or negedge n_rst) begin
    if (!n_rst) begin
      wbin_q  <= '0;
      wgray_q <= '0;
      fill_q  <= '0;
      full_q  <= 1'b0;
      af_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      wbin_q  <= wbin_d;
      wgray_q <= wgray_d;
      fill_q  <= fill_d;
      full_q  <= full_d;
      af_q    <= af_d;
      ovf_q   <= ovf_d;
    end
  end

  assign w_addr_o      = wbin_q[ADDR_W-1:0];
  assign wptr_gray_o   = wgray_q;
  assign full_o        = full_q;
  assign almost_full_o = af_q;
  assign w_fill_o      = fill_q;
  assign overflow_o    = ovf_q;

endmodule

// File: tb/tb_fifo_wr_ctrl.sv
// tb/tb_fifo_wr_ctrl.sv - directed self-checking bench for fifo_wr_ctrl
module tb_fifo_wr_ctrl;

  localparam int ADDR_W = 6;
  localparam int PW     = ADDR_W + 1;
  localparam int LAG    = 1;  // SYNC_STAGES - 1 edges between sampling rptr and its use
`ifdef FIFO_WR_ALMOST_FULL_EN
  localparam bit AF_EN = 1'b1;
`else
  localparam bit AF_EN = 1'b0;
`endif

  logic              w_clk;
  logic              n_rst;
  logic              w_en;
  logic              ovf_clr;
  logic [PW-1:0]     rptr_gray;
  logic [ADDR_W-1:0] w_addr;
  logic [PW-1:0]     wptr_gray;
  logic              full;
  logic              almost_full;
  logic [PW-1:0]     w_fill;
  logic              overflow;

  int total = 0;
  int bad   = 0;

  logic [PW-1:0] hist [300];
  logic [PW-1:0] prev_gray;
  logic [PW-1:0] rb;
  logic [PW-1:0] exp_fill;

  fifo_wr_ctrl #(
    .ADDR_W      (ADDR_W),
    .AF_LEVEL    (4),
    .SYNC_STAGES (2)
  ) dut (
    .w_clk         (w_clk),
    .n_rst         (n_rst),
    .w_en_i        (w_en),
    .ovf_clr_i     (ovf_clr),
    .rptr_gray_i   (rptr_gray),
    .w_addr_o      (w_addr),
    .wptr_gray_o   (wptr_gray),
    .full_o        (full),
    .almost_full_o (almost_full),
    .w_fill_o      (w_fill),
    .overflow_o    (overflow)
  );

  initial w_clk = 1'b0;
  always #5 w_clk = ~w_clk;

  function automatic logic [PW-1:0] g(input logic [PW-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [31:0] fx(input logic [31:0] v);
    return AF_EN ? v : 32'd0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge w_clk);
    #1;
  endtask

  initial begin
    n_rst     = 1'b1;
    w_en      = 1'b1;
    ovf_clr   = 1'b0;
    rptr_gray = '0;
    #2 n_rst  = 1'b0;

    // reset held with w_en asserted
    tick(); tick(); tick();
    chk("rst_w_addr", 32'(w_addr), 32'd0);
    chk("rst_wptr_gray", 32'(wptr_gray), 32'd0);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_almost_full", 32'(almost_full), 32'd0);
    chk("rst_w_fill", 32'(w_fill), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);

    n_rst = 1'b1;
    tick();
    chk("first_w_addr", 32'(w_addr), 32'd1);
    chk("first_wptr_gray", 32'(wptr_gray), 32'h01);
    chk("first_w_fill", 32'(w_fill), fx(32'd1));

    // fill to DEPTH with rptr held at 0
    for (int w = 2; w <= 64; w++) begin
      tick();
      if (w == 59) chk("af_before_60", 32'(almost_full), fx(32'd0));
      if (w == 60) begin
        chk("af_at_60", 32'(almost_full), fx(32'd1));
        chk("fill_at_60", 32'(w_fill), fx(32'd60));
      end
      if (w == 63) chk("full_at_63", 32'(full), 32'd0);
    end
    chk("full_at_64", 32'(full), 32'd1);
    chk("fill_at_64", 32'(w_fill), fx(32'd64));
    chk("gray_at_64", 32'(wptr_gray), 32'h60);
    chk("addr_at_64", 32'(w_addr), 32'd0);

    // write while full; clear in the same cycle as set loses
    ovf_clr = 1'b1;
    tick();
    chk("ovf_set_wins", 32'(overflow), 32'd1);
    chk("ovf_addr_0", 32'(w_addr), 32'd0);
    chk("ovf_fill_0", 32'(w_fill), fx(32'd64));
    ovf_clr = 1'b0;
    for (int c = 1; c < 3; c++) begin
      tick();
      chk("ovf_hold", 32'(overflow), 32'd1);
      chk("ovf_addr", 32'(w_addr), 32'd0);
      chk("ovf_fill", 32'(w_fill), fx(32'd64));
      chk("ovf_gray", 32'(wptr_gray), 32'h60);
    end
    w_en    = 1'b0;
    ovf_clr = 1'b1;
    tick();
    chk("ovf_cleared", 32'(overflow), 32'd0);
    ovf_clr = 1'b0;

    // read pointer advance becomes visible SYNC_STAGES edges later
    rptr_gray = 7'h01;
    tick();
    chk("rd_edge1_full", 32'(full), 32'd1);
    chk("rd_edge1_fill", 32'(w_fill), fx(32'd64));
    tick();
    chk("rd_edge2_full", 32'(full), 32'd0);
    chk("rd_edge2_fill", 32'(w_fill), fx(32'd63));
    chk("rd_edge2_af", 32'(almost_full), fx(32'd1));

    // asynchronous reset mid-operation
    n_rst = 1'b0;
    #1;
    chk("arst_w_addr", 32'(w_addr), 32'd0);
    chk("arst_gray", 32'(wptr_gray), 32'd0);
    chk("arst_fill", 32'(w_fill), 32'd0);
    rptr_gray = '0;
    w_en      = 1'b1;
    tick();
    n_rst = 1'b1;

    // stream with the read pointer trailing the writes
    prev_gray = '0;
    for (int i = 0; i < 300; i++) begin
      rb        = (i >= 8) ? PW'(i - 8) : '0;
      hist[i]   = rb;
      rptr_gray = g(rb);
      tick();
      exp_fill = PW'(i + 1) - ((i >= LAG) ? hist[i-LAG] : '0);
      chk("wrap_addr", 32'(w_addr), 32'((i + 1) % 64));
      chk("wrap_gray", 32'(wptr_gray), 32'(g(PW'(i + 1))));
      chk("wrap_gray_1bit", 32'($countones(wptr_gray ^ prev_gray)), 32'd1);
      chk("wrap_full", 32'(full), 32'd0);
      chk("wrap_fill", 32'(w_fill), fx(32'(exp_fill)));
      if (i >= 9) chk("wrap_fill_band", 32'((w_fill == 7'd10) || (w_fill == 7'd11)), fx(32'd1));
      prev_gray = wptr_gray;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fifo_wr_ctrl.md
# fifo_wr_ctrl

Parametrised write-side controller for the output-buffer asynchronous FIFO. It owns the write pointer in binary and Gray form and synchronises the read-domain Gray pointer into w_clk. It produces registered full, almost-full, fill-level and sticky-overflow flags. It sits between the write-domain producer and the dual-port RAM, and pairs with the read-side controller across the clock boundary.

## Interface
- ADDR_W, 6, RAM address width; DEPTH = 2**ADDR_W entries; pointers are ADDR_W+1 bits.
- AF_LEVEL, 4, almost_full threshold in free entries; legal range 1 to DEPTH-1.
- SYNC_STAGES, 2, flop stages in the read-pointer synchroniser; minimum 2.
- w_clk  in  1  write clock.
- n_rst  in  1  reset, asynchronous, active-low.
- w_en  in  1  write request; accepted only when full==0.
- ovf_clr  in  1  clears the sticky overflow flag.
- rptr_gray  in  ADDR_W+1  read pointer in Gray code, from the read domain; asynchronous to w_clk.
- w_addr  out  ADDR_W  RAM write address: low bits of the binary write pointer.
- wptr_gray  out  ADDR_W+1  registered Gray write pointer, sent to the read domain.
- full  out  1  FIFO holds DEPTH entries.
- almost_full  out  1  free entries <= AF_LEVEL.
- w_fill  out  ADDR_W+1  occupied entries as seen from the write domain, 0..DEPTH.
- overflow  out  1  sticky flag: a write was attempted while full.

## Operation
- Accept = w_en & ~full. The binary pointer increments by the accept value modulo 2**(ADDR_W+1); wptr_gray = bin ^ (bin>>1) of the next binary value, registered.
- rptr_gray passes through SYNC_STAGES flops (reset 0). The synchronised Gray value is converted to binary (rbin_s) for fill arithmetic only.
- full_n is set when the next Gray write pointer differs from the synchronised read Gray pointer in the top two bits and matches it in all remaining bits.
- w_fill_n = wbin_n - rbin_s, computed ADDR_W+1 bits wide with natural wrap. full==1 exactly when w_fill==DEPTH.
- almost_full_n = (w_fill_n >= DEPTH-AF_LEVEL).
- Overflow: w_en & full sets overflow on the next edge. ovf_clr clears it. If set and clear occur in the same cycle, set wins.
- Write while full: the pointers, w_addr and w_fill are unchanged; the RAM must not be written (the RAM write enable is the accept signal).
- Wrap-around: the pointer wraps from 2**(ADDR_W+1)-1 to 0 with no special case. Gray and full remain correct across the wrap.
- Reset mid-operation asserts everything immediately. The read side must be reset in the same reset domain.

## Timing
- Reset values: w_addr=0, wptr_gray=0, full=0, almost_full=0, w_fill=0, overflow=0, synchroniser stages=0.
- When a write is accepted at edge N, w_addr, wptr_gray, w_fill and full reflect it at edge N. The write has zero added latency beyond its own edge.
- A read-pointer change sampled at edge k updates full, almost_full and w_fill at edge k+SYNC_STAGES-1. The flags are conservative, never optimistic.
- A simultaneous write and read-pointer advance nets to an unchanged w_fill once the read pointer is visible.
- All outputs are registered; there are no combinational paths from input to output.

## Configuration
- FIFO_WR_ALMOST_FULL_EN defined: the gray-to-binary converter, the w_fill subtractor and the almost_full comparator are built as described above.
- FIFO_WR_ALMOST_FULL_EN undefined: w_fill and almost_full are tied to 0 and no binary conversion is built. full, the pointers, overflow and the synchroniser are unchanged. Ports stay present in both builds.

## Structure
- fifo_pkg holds the shared items used by both FIFO controllers:
  - the bin2gray and gray2bin functions, parametrised by width;
  - the DEPTH and pointer-width derivation helpers.
- Sub-module gray_sync: a generic WIDTH x SYNC_STAGES flop chain with asynchronous active-low reset. The read side reuses it.

## Test plan
- Reset with w_en=1 held -> all outputs 0 during reset. First accepted write on the first edge after release gives w_addr=1 and wptr_gray=0x01.
- rptr_gray=0 held, 64 consecutive writes (ADDR_W=6):
  - almost_full=1 after the 60th write, with w_fill=60;
  - full=1 after the 64th write, with w_fill=64, wptr_gray=0x60 and w_addr=0.
- While full, w_en=1 for 3 cycles -> w_addr and w_fill are unchanged and overflow=1 persists.
- In the cycle overflow is set, ovf_clr=1 -> overflow stays 1. ovf_clr=1 on a cycle with no write attempt while full -> overflow=0 on the next edge.
- From full, rptr_gray is driven to gray(1)=0x01 -> full=0 and w_fill=63 exactly SYNC_STAGES edges later, not earlier.
- Wrap-around: stream 300 writes with rptr_gray tracking 10 entries behind -> w_fill is always 10 or 11, full is never set, and wptr_gray changes one bit per accepted write, including the 127->0 wrap.
